// File: rtl/addsub_result_fifo.sv
// addsub_result_fifo: captures adder/subtractor results with derived flags into a FWFT FIFO,
// and tracks a sticky overflow flag plus a count of accepted results.
module addsub_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_m,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_carry,
  output logic                     out_ovf,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_mode,
  output logic                     ovf_sticky,
  input  logic                     clr,
  output logic [CNT_W-1:0]         acc_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int P = $clog2(DEPTH);
  localparam int E = WIDTH + 5;
  logic [E-1:0]     r_mem [DEPTH];
  logic [P-1:0]     r_wr, r_rd;
  logic [P:0]       r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             w_push, w_pop, w_ovf;
  logic [E-1:0]     w_entry, w_head;
  always_comb begin
    in_ready  = r_level != (P+1)'(DEPTH);
    out_valid = r_level != '0;
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    w_ovf     = ~(in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ in_m) & (in_sum[WIDTH-1] ^ in_a[WIDTH-1]);
    w_entry   = {in_m, in_sum[WIDTH-1], ~|in_sum, w_ovf, in_m ? ~in_cout : in_cout, in_sum};
    // Data fields are forced to zero while the FIFO is empty.
    w_head    = out_valid ? r_mem[r_rd] : '0;
  end
  assign {out_mode, out_neg, out_zero, out_ovf, out_carry, out_sum} = w_head;
  assign level      = r_level;
  assign acc_count  = r_cnt;
  assign ovf_sticky = r_sticky;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + P'(1);
      if (w_pop) r_rd <= r_rd + P'(1);
      r_level  <= r_level + (P+1)'(w_push) - (P+1)'(w_pop);
      // Clear takes effect before a same-cycle push.
      r_cnt    <= (clr ? '0 : r_cnt) + CNT_W'(w_push);
      r_sticky <= (clr ? 1'b0 : r_sticky) | (w_push & w_ovf);
    end
  end
endmodule

// File: doc/addsub_result_fifo.md
Name: addsub_result_fifo

Overview:
- Downstream consumer of the 4-bit adder/subtractor (`sum`, `cout` for operands `a`, `b` and mode `m`; `m=1` means subtract, computed as `a + ~b + 1`).
- Each cycle with an accepted handshake it captures one result and derives status flags: borrow, signed overflow, zero and negative.
- Results are buffered in a small FIFO and presented on a valid/ready output port.
- It also keeps a sticky overflow indicator and a count of accepted results for the control logic.

Parameters:
- `WIDTH`, 4, operand/result width; matches the adder width.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `CNT_W`, 8, width of the accepted-result counter.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the adder output and operands are valid this cycle.
- `in_ready` output 1: FIFO can accept an entry.
- `in_a` input `WIDTH`: operand `a` presented to the adder.
- `in_b` input `WIDTH`: operand `b` presented to the adder.
- `in_m` input 1: adder mode, 0 = add, 1 = subtract.
- `in_sum` input `WIDTH`: adder `sum`.
- `in_cout` input 1: adder `cout`.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_sum` output `WIDTH`: head result.
- `out_carry` output 1: add mode gives `cout`; sub mode gives borrow (`~cout`).
- `out_ovf` output 1: signed two's-complement overflow.
- `out_zero` output 1: `out_sum == 0`.
- `out_neg` output 1: `out_sum[WIDTH-1]`.
- `out_mode` output 1: `m` of the head entry.
- `ovf_sticky` output 1: set by any accepted entry with overflow.
- `clr` input 1: synchronous clear of `ovf_sticky` and `acc_count`.
- `acc_count` output `CNT_W`: number of accepted inputs, wraps modulo 2^`CNT_W`.
- `level` output `$clog2(DEPTH)+1`: current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, `level=0`, `out_valid=0`, `in_ready=1`, `ovf_sticky=0`, `acc_count=0`. All `out_*` data fields read 0 while empty.
- Push occurs when `in_valid & in_ready`. Pop occurs when `out_valid & out_ready`.
- `in_ready = (level != DEPTH)`. It does not depend on `out_ready` in the same cycle (no combinational ready path).
- Flag computation is combinational on the inputs and stored with the entry:
  - `carry = in_m ? ~in_cout : in_cout`.
  - `ovf = ~(in_a[W-1] ^ in_b[W-1] ^ in_m) & (in_sum[W-1] ^ in_a[W-1])`.
  - `zero = ~|in_sum`.
  - `neg = in_sum[W-1]`.
- Output is first-word-fall-through. The head entry is visible while `out_valid=1`; `out_*` fields are stable while `out_valid & ~out_ready`.
- Latency: an entry pushed in cycle N appears at the output in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop with `0<level<DEPTH`: both occur and `level` is unchanged.
- Full: no push is possible (`in_ready=0`), so data is held upstream. A pop in a full cycle makes `in_ready=1` in the next cycle.
- Empty: `out_valid=0` and `out_ready` is ignored. `level` never underflows or overflows.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- `acc_count` increments by 1 on each push and wraps from 2^`CNT_W`-1 to 0.
- `ovf_sticky` is set on a push with `ovf=1`. Priority: `clr` in the same cycle as an overflow push gives `ovf_sticky=1` and `acc_count=1`, i.e. the clear is applied first, then the push.
- `rst_n` asserted mid-operation immediately empties the FIFO and forces all reset values; entries in flight are discarded.

Test Plan:
- Sub case: after reset, push `m=1`, `a=0111`, `b=0001`, `sum=0110`, `cout=1` -> next cycle `out_valid=1`, `out_sum=0110`, `carry=0`, `ovf=0`, `zero=0`, `neg=0`, `mode=1`, `acc_count=1`.
- Add overflow: push `m=0`, `a=0111`, `b=0001`, `sum=1000`, `cout=0` -> `ovf=1`, `neg=1`, `carry=0`, `ovf_sticky=1`. Then pulse `clr` -> `ovf_sticky=0`, `acc_count=0`.
- Sub borrow plus overflow: push `m=1`, `a=0010`, `b=1000`, `sum=1010`, `cout=0` -> `carry=1` (borrow), `ovf=1`, `neg=1`. Also push `m=1`, `a=0011`, `b=0011`, `sum=0000`, `cout=1` -> `zero=1`, `carry=0`.
- Full/backpressure: `out_ready=0`, push 5 consecutive entries -> `in_ready` goes 0 after the 4th, `level=4`, 5th not accepted. Raise `out_ready` -> entries drain in order, and one cycle after the first pop `in_ready=1`.
- Simultaneous push/pop at `level=2` for 6 cycles -> `level` stays 2, output order matches input order, pointers wrap correctly.
- Reset mid-stream with `level=3` -> same cycle `out_valid=0`, `level=0`, `acc_count=0`. After release, a first push appears at the output one cycle later.
